// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns a tagged, registered result.
module alu_scheduler #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_req0_valid,
    input  logic [NB_DATA-1:0]   i_req0_a,
    input  logic [NB_DATA-1:0]   i_req0_b,
    input  logic [NB_OPCODE-1:0] i_req0_op,
    output logic                 o_req0_ready,
    input  logic                 i_req1_valid,
    input  logic [NB_DATA-1:0]   i_req1_a,
    input  logic [NB_DATA-1:0]   i_req1_b,
    input  logic [NB_OPCODE-1:0] i_req1_op,
    output logic                 o_req1_ready,
    output logic [NB_DATA-1:0]   o_alu_a,
    output logic [NB_DATA-1:0]   o_alu_b,
    output logic [NB_OPCODE-1:0] o_alu_op,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_rsp_valid,
    output logic                 o_rsp_id,
    output logic [NB_DATA-1:0]   o_rsp_result,
    output logic                 o_rsp_error,
    input  logic                 i_rsp_ready
);

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 last_grant;
    logic                 grant;
    logic                 grant_valid;
    logic                 accept;
    logic                 op_legal;
    logic [NB_DATA-1:0]   alu_a;
    logic [NB_DATA-1:0]   alu_b;
    logic [NB_OPCODE-1:0] alu_op;
    logic                 rsp_id;
    logic [NB_DATA-1:0]   rsp_result;
    logic                 rsp_error;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        grant_valid = i_req0_valid | i_req1_valid;
        grant       = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant = ~last_grant;
        end else if (i_req1_valid) begin
            grant = 1'b1;
        end
    end

    // Gating with i_reset keeps both readies low while reset is held.
    assign o_req0_ready = i_reset && (state == IDLE) && grant_valid && !grant;
    assign o_req1_ready = i_reset && (state == IDLE) && grant_valid && grant;
    assign accept       = (o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid);

    always_comb begin
        op_legal = 1'b0;
        case (alu_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (i_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a      <= grant ? i_req1_a  : i_req0_a;
                alu_b      <= grant ? i_req1_b  : i_req0_b;
                alu_op     <= grant ? i_req1_op : i_req0_op;
                rsp_id     <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                rsp_result <= op_legal ? i_alu_result : '0;
                rsp_error  <= !op_legal;
            end
        end
    end

    assign o_alu_a      = alu_a;
    assign o_alu_b      = alu_b;
    assign o_alu_op     = alu_op;
    assign o_rsp_valid  = (state == RESP);
    assign o_rsp_id     = rsp_id;
    assign o_rsp_result = rsp_result;
    assign o_rsp_error  = rsp_error;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU closing the loop.
// Expected results are hand-computed constants.
module tb_alu_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0] req0_op, req1_op;
    logic       req0_ready, req1_ready;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [5:0] alu_op;
    logic       rsp_valid, rsp_id, rsp_error, rsp_ready;
    logic [7:0] rsp_result;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_scheduler #(.NB_DATA(8), .NB_OPCODE(6)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_req0_valid (req0_valid),
        .i_req0_a     (req0_a),
        .i_req0_b     (req0_b),
        .i_req0_op    (req0_op),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_a     (req1_a),
        .i_req1_b     (req1_b),
        .i_req1_op    (req1_op),
        .o_req1_ready (req1_ready),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_error  (rsp_error),
        .i_rsp_ready  (rsp_ready)
    );

    // Unknown opcodes return a non-zero pattern so a leaked result is visible.
    always_comb begin
        case (alu_op)
            6'b100000: alu_result = alu_a + alu_b;
            6'b100010: alu_result = alu_a - alu_b;
            6'b100100: alu_result = alu_a & alu_b;
            6'b100101: alu_result = alu_a | alu_b;
            6'b100110: alu_result = alu_a ^ alu_b;
            6'b000011: alu_result = $unsigned($signed(alu_a) >>> alu_b[2:0]);
            6'b000010: alu_result = alu_a >> alu_b[2:0];
            6'b100111: alu_result = ~(alu_a | alu_b);
            default:   alu_result = 8'hA5;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated request from IDLE through response handshake.
    task automatic do_op(input string tag, input logic id, input logic [5:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic err);
        if (!id) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        #1;
        chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_exec_valid"}, rsp_valid, 0);
        tick();
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_error"}, rsp_error, err);
        rsp_ready = 1'b1;
        tick();
        chk({tag, "_done"}, rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask

    logic [5:0] t_op  [9];
    logic [7:0] t_a   [9];
    logic [7:0] t_b   [9];
    logic [7:0] t_res [9];
    logic       t_err [9];

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 8'h00; req0_b = 8'h00; req0_op = 6'h00;
        req1_a = 8'h00; req1_b = 8'h00; req1_op = 6'h00;
        rsp_ready = 1'b0;

        t_op[0] = 6'b100000; t_a[0] = 8'h7F; t_b[0] = 8'h02; t_res[0] = 8'h81; t_err[0] = 1'b0;
        t_op[1] = 6'b100010; t_a[1] = 8'h05; t_b[1] = 8'h07; t_res[1] = 8'hFE; t_err[1] = 1'b0;
        t_op[2] = 6'b100100; t_a[2] = 8'hCC; t_b[2] = 8'hAA; t_res[2] = 8'h88; t_err[2] = 1'b0;
        t_op[3] = 6'b100101; t_a[3] = 8'hCC; t_b[3] = 8'hAA; t_res[3] = 8'hEE; t_err[3] = 1'b0;
        t_op[4] = 6'b100110; t_a[4] = 8'hCC; t_b[4] = 8'hAA; t_res[4] = 8'h66; t_err[4] = 1'b0;
        t_op[5] = 6'b000011; t_a[5] = 8'h80; t_b[5] = 8'h03; t_res[5] = 8'hF0; t_err[5] = 1'b0;
        t_op[6] = 6'b000010; t_a[6] = 8'h80; t_b[6] = 8'h03; t_res[6] = 8'h10; t_err[6] = 1'b0;
        t_op[7] = 6'b100111; t_a[7] = 8'hCC; t_b[7] = 8'hAA; t_res[7] = 8'h11; t_err[7] = 1'b0;
        t_op[8] = 6'b100001; t_a[8] = 8'h11; t_b[8] = 8'h22; t_res[8] = 8'h00; t_err[8] = 1'b1;

        // Reset state, with a request already pending
        tick();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        #1;

        // Single ADD with latency check
        do_op("add_single", 1'b0, 6'b100000, 8'h05, 8'h03, 8'h08, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("op%0d", i), 1'b0, t_op[i], t_a[i], t_b[i], t_res[i], t_err[i]);
        end

        do_op("illegal_req1", 1'b1, 6'b111111, 8'h12, 8'h34, 8'h00, 1'b1);

        // Contention after a fresh reset: order must be 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_a = 8'h21; req0_b = 8'h12; req0_op = 6'b100000; req0_valid = 1'b1;
        req1_a = 8'h50; req1_b = 8'h20; req1_op = 6'b100010; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_ready0", k), req0_ready, (k % 2) == 0);
            chk($sformatf("rr%0d_ready1", k), req1_ready, (k % 2) == 1);
            tick();
            chk($sformatf("rr%0d_exec_valid", k), rsp_valid, 0);
            tick();
            chk($sformatf("rr%0d_valid", k), rsp_valid, 1);
            chk($sformatf("rr%0d_id", k), rsp_id, k % 2);
            chk($sformatf("rr%0d_result", k), rsp_result, (k % 2) ? 8'h30 : 8'h33);
            chk($sformatf("rr%0d_busy_ready", k), {req0_ready, req1_ready}, 0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;

        // Backpressure: 5 stalled cycles in RESP with both requesters waiting
        req0_a = 8'hF0; req0_b = 8'h0F; req0_op = 6'b100101; req0_valid = 1'b1;
        #1;
        chk("bp_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), rsp_valid, 1);
            chk($sformatf("bp%0d_id", i), rsp_id, 0);
            chk($sformatf("bp%0d_result", i), rsp_result, 8'hFF);
            chk($sformatf("bp%0d_error", i), rsp_error, 0);
            chk($sformatf("bp%0d_ready", i), {req0_ready, req1_ready}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_next_ready0", req0_ready, 0);
        chk("bp_next_ready1", req1_ready, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;

        // Reset during EXEC drops the operation
        req0_a = 8'h3C; req0_b = 8'h0F; req0_op = 6'b100100; req0_valid = 1'b1;
        #1;
        chk("mid_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid_quiet%0d", i), rsp_valid, 0);
        end
        rsp_ready = 1'b0;
        do_op("post_rst_sub", 1'b0, 6'b100010, 8'h10, 8'h01, 8'h0F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
